// File: rtl/pipe_eu.sv
// Three-stage execute pipeline (ID, EX, MW) with EX/MW forwarding, a load-use
// interlock and a memory port that tolerates any acknowledge latency.
module pipe_eu #(
    parameter  int DW   = 32,
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [25:0]   Instruction,
    input  logic          RegDst,
    input  logic          ALUSrc,
    input  logic          RegWrite,
    input  logic          MemtoReg,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [1:0]    ALUOp,
    output logic [DW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_re,
    output logic          ram_we,
    input  logic          ram_ack,
    output logic [DW-1:0] SEImm,
    output logic          Zero,
    output logic          wb_valid,
    output logic [RW-1:0] wb_reg,
    output logic [DW-1:0] wb_data
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SLT = 3'd5
    } alu_op_t;

    // decode-stage signals
    logic [RW-1:0] id_rs_s, id_rt_s, id_rd_s, id_dest_s;
    logic [DW-1:0] id_imm_s, id_a_s, id_b_s;
    logic          accept_s, hazard_s, advance_s;

    // ID/EX register
    logic          ex_valid_r;
    logic [DW-1:0] ex_a_r, ex_b_r, ex_imm_r;
    logic [RW-1:0] ex_rs_r, ex_rt_r, ex_dest_r;
    logic [1:0]    ex_aluop_r;
    logic [5:0]    ex_funct_r;
    logic          ex_alusrc_r, ex_regwrite_r, ex_memtoreg_r, ex_memread_r, ex_memwrite_r;

    // EX/MW register
    logic          mw_valid_r;
    logic [DW-1:0] mw_alu_r, mw_store_r;
    logic [RW-1:0] mw_dest_r;
    logic          mw_regwrite_r, mw_memtoreg_r, mw_memread_r, mw_memwrite_r;
    logic          zero_r;

    logic [DW-1:0] rf_r [NREG];

    alu_op_t       op_s;
    logic [DW-1:0] fwd_a_s, fwd_b_s, alu_b_s, alu_s;
    logic          mw_rd_s, mw_wr_s, mw_stall_s;
    logic          wb_fire_s, fwd_ok_s;
    logic [DW-1:0] wb_result_s;
    logic          unused_bits_s;

    assign unused_bits_s = ^Instruction;

    assign id_rs_s   = Instruction[21 +: RW];
    assign id_rt_s   = Instruction[16 +: RW];
    assign id_rd_s   = Instruction[11 +: RW];
    assign id_dest_s = RegDst ? id_rd_s : id_rt_s;
    assign id_imm_s  = DW'($signed(Instruction[15:0]));

    // Memory stage: a read wins when both strobes are requested.
    assign mw_rd_s     = mw_valid_r & mw_memread_r;
    assign mw_wr_s     = mw_valid_r & mw_memwrite_r & ~mw_memread_r;
    assign mw_stall_s  = (mw_rd_s | mw_wr_s) & ~ram_ack;
    assign advance_s   = ~mw_stall_s;
    assign wb_result_s = mw_memtoreg_r ? ram_rdata : mw_alu_r;
    assign fwd_ok_s    = mw_valid_r & mw_regwrite_r & (mw_dest_r != {RW{1'b0}});
    assign wb_fire_s   = fwd_ok_s & ~mw_stall_s;

    // Register read; a write landing on the same edge is bypassed.
    assign id_a_s = (wb_fire_s && (mw_dest_r == id_rs_s)) ? wb_result_s : rf_r[id_rs_s];
    assign id_b_s = (wb_fire_s && (mw_dest_r == id_rt_s)) ? wb_result_s : rf_r[id_rt_s];

    assign hazard_s = ex_valid_r & ex_memread_r & (ex_dest_r != {RW{1'b0}}) &
                      ((ex_dest_r == id_rs_s) |
                       ((~ALUSrc | MemWrite) & (ex_dest_r == id_rt_s)));
    assign in_ready = ~mw_stall_s & ~hazard_s;
    assign accept_s = in_valid & in_ready;

    assign fwd_a_s = (fwd_ok_s && (mw_dest_r == ex_rs_r)) ? wb_result_s : ex_a_r;
    assign fwd_b_s = (fwd_ok_s && (mw_dest_r == ex_rt_r)) ? wb_result_s : ex_b_r;
    assign alu_b_s = ex_alusrc_r ? ex_imm_r : fwd_b_s;

    // ALU operation select and datapath
    always_comb begin
        op_s = OP_ADD;
        case (ex_aluop_r)
            2'b00: op_s = OP_ADD;
            2'b01: op_s = OP_SUB;
            2'b10: begin
                case (ex_funct_r)
                    6'b100000: op_s = OP_ADD;
                    6'b100010: op_s = OP_SUB;
                    6'b100100: op_s = OP_AND;
                    6'b100101: op_s = OP_OR;
                    6'b100111: op_s = OP_NOR;
                    6'b101010: op_s = OP_SLT;
                    default:   op_s = OP_ADD;
                endcase
            end
            2'b11:   op_s = OP_OR;
            default: op_s = OP_ADD;
        endcase
        alu_s = {DW{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = fwd_a_s + alu_b_s;
            OP_SUB:  alu_s = fwd_a_s - alu_b_s;
            OP_AND:  alu_s = fwd_a_s & alu_b_s;
            OP_OR:   alu_s = fwd_a_s | alu_b_s;
            OP_NOR:  alu_s = ~(fwd_a_s | alu_b_s);
            OP_SLT:  alu_s = ($signed(fwd_a_s) < $signed(alu_b_s)) ?
                             {{(DW-1){1'b0}}, 1'b1} : {DW{1'b0}};
            default: alu_s = fwd_a_s + alu_b_s;
        endcase
    end

    // ID/EX pipeline register; holds while the memory stage waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r    <= 1'b0;
            ex_a_r        <= {DW{1'b0}};
            ex_b_r        <= {DW{1'b0}};
            ex_imm_r      <= {DW{1'b0}};
            ex_rs_r       <= {RW{1'b0}};
            ex_rt_r       <= {RW{1'b0}};
            ex_dest_r     <= {RW{1'b0}};
            ex_aluop_r    <= 2'b00;
            ex_funct_r    <= 6'd0;
            ex_alusrc_r   <= 1'b0;
            ex_regwrite_r <= 1'b0;
            ex_memtoreg_r <= 1'b0;
            ex_memread_r  <= 1'b0;
            ex_memwrite_r <= 1'b0;
        end else if (advance_s) begin
            ex_valid_r    <= accept_s;
            ex_a_r        <= id_a_s;
            ex_b_r        <= id_b_s;
            ex_imm_r      <= id_imm_s;
            ex_rs_r       <= id_rs_s;
            ex_rt_r       <= id_rt_s;
            ex_dest_r     <= id_dest_s;
            ex_aluop_r    <= ALUOp;
            ex_funct_r    <= Instruction[5:0];
            ex_alusrc_r   <= ALUSrc;
            ex_regwrite_r <= RegWrite;
            ex_memtoreg_r <= MemtoReg;
            ex_memread_r  <= MemRead;
            ex_memwrite_r <= MemWrite;
        end
    end

    // EX/MW pipeline register and Zero flag; bubbles leave Zero untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_valid_r    <= 1'b0;
            mw_alu_r      <= {DW{1'b0}};
            mw_store_r    <= {DW{1'b0}};
            mw_dest_r     <= {RW{1'b0}};
            mw_regwrite_r <= 1'b0;
            mw_memtoreg_r <= 1'b0;
            mw_memread_r  <= 1'b0;
            mw_memwrite_r <= 1'b0;
            zero_r        <= 1'b0;
        end else if (advance_s) begin
            mw_valid_r    <= ex_valid_r;
            mw_alu_r      <= alu_s;
            mw_store_r    <= fwd_b_s;
            mw_dest_r     <= ex_dest_r;
            mw_regwrite_r <= ex_regwrite_r;
            mw_memtoreg_r <= ex_memtoreg_r;
            mw_memread_r  <= ex_memread_r;
            mw_memwrite_r <= ex_memwrite_r;
            if (ex_valid_r) begin
                zero_r <= (alu_s == {DW{1'b0}});
            end
        end
    end

    // Register file; register 0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
        end else if (wb_fire_s) begin
            rf_r[mw_dest_r] <= wb_result_s;
        end
    end

    assign ram_re    = mw_rd_s;
    assign ram_we    = mw_wr_s;
    assign ram_addr  = mw_alu_r;
    assign ram_wdata = mw_store_r;
    assign SEImm     = ex_imm_r;
    assign Zero      = zero_r;
    assign wb_valid  = wb_fire_s;
    assign wb_reg    = wb_fire_s ? mw_dest_r : {RW{1'b0}};
    assign wb_data   = wb_fire_s ? wb_result_s : {DW{1'b0}};

endmodule

// File: tb/tb_pipe_eu.sv
// Scoreboard bench for pipe_eu: expected writebacks are queued at issue and
// matched against the writeback port; a second 16-bit build is also exercised.
module tb_pipe_eu;

    localparam logic [7:0] C_R    = 8'b1_0_1_0_0_0_10;
    localparam logic [7:0] C_ADDI = 8'b0_1_1_0_0_0_00;
    localparam logic [7:0] C_LW   = 8'b0_1_1_1_1_0_00;
    localparam logic [7:0] C_SW   = 8'b0_1_0_0_0_1_00;
    localparam logic [7:0] C_ORI  = 8'b0_1_1_0_0_0_11;
    localparam logic [7:0] C_SUBR = 8'b1_0_1_0_0_0_01;
    localparam logic [7:0] C_LWSW = 8'b0_1_1_1_1_1_00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready;
    logic [25:0] ins;
    logic [7:0]  ctl;
    logic [31:0] ram_addr, ram_wdata, ram_rdata, seimm, wb_data;
    logic        ram_re, ram_we, ram_ack, zero, wb_valid;
    logic [4:0]  wb_reg;

    logic        in_valid2, in_ready2;
    logic [25:0] ins2;
    logic [7:0]  ctl2;
    logic [15:0] ram_addr2, ram_wdata2, ram_rdata2, seimm2, wb_data2;
    logic        ram_re2, ram_we2, ram_ack2, zero2, wb_valid2;
    logic [2:0]  wb_reg2;

    pipe_eu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(ins), .RegDst(ctl[7]), .ALUSrc(ctl[6]), .RegWrite(ctl[5]),
        .MemtoReg(ctl[4]), .MemRead(ctl[3]), .MemWrite(ctl[2]), .ALUOp(ctl[1:0]),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_re(ram_re), .ram_we(ram_we), .ram_ack(ram_ack), .SEImm(seimm),
        .Zero(zero), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    pipe_eu #(.DW(16), .NREG(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .Instruction(ins2), .RegDst(ctl2[7]), .ALUSrc(ctl2[6]), .RegWrite(ctl2[5]),
        .MemtoReg(ctl2[4]), .MemRead(ctl2[3]), .MemWrite(ctl2[2]), .ALUOp(ctl2[1:0]),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
        .ram_re(ram_re2), .ram_we(ram_we2), .ram_ack(ram_ack2), .SEImm(seimm2),
        .Zero(zero2), .wb_valid(wb_valid2), .wb_reg(wb_reg2), .wb_data(wb_data2)
    );

    typedef struct {
        int          r;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ack_lat = 0;
    int   wcnt    = 0;
    logic stray_ack = 1'b0;
    int   w;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] rt_f(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [25:0] it_f(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: acknowledges a request after ack_lat waiting cycles
    initial begin
        ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_re || ram_we) begin
                ram_ack = (wcnt >= ack_lat);
                wcnt    = ram_ack ? 0 : wcnt + 1;
            end else begin
                ram_ack = stray_ack;
                wcnt    = 0;
            end
        end
    end

    // writeback scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && wb_valid) begin
                if (sbq.size() == 0) begin
                    check_val("wb_extra", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    check_val("wb_reg", 64'(wb_reg), 64'(e.r));
                    check_val("wb_data", 64'(wb_data), 64'(e.d));
                    if (e.c >= 0) check_val("wb_cycle", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    task automatic issue(input logic [25:0] i, input logic [7:0] c, input int er,
                         input logic [31:0] ed, input bit has_wb, input bit tchk,
                         output int waits);
        exp_t e;
        @(negedge clk);
        ins = i;
        ctl = c;
        in_valid = 1'b1;
        waits = 0;
        #1;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (has_wb) begin
            e.r = er;
            e.d = ed;
            e.c = tchk ? cyc + 1 : -1;
            sbq.push_back(e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; ins = 26'd0; ctl = 8'd0; ram_rdata = 32'd0;
        in_valid2 = 1'b0; ins2 = 26'd0; ctl2 = 8'd0; ram_rdata2 = 16'd0; ram_ack2 = 1'b0;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_ram_re", 64'(ram_re), 64'd0);
        check_val("rst_ram_we", 64'(ram_we), 64'd0);
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_zero", 64'(zero), 64'd0);
        check_val("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_val("rst_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

        // forwarding chain
        issue(it_f(5'd0, 5'd1, 16'd5), C_ADDI, 1, 32'd5, 1'b1, 1'b1, w);
        issue(rt_f(5'd1, 5'd1, 5'd2, 6'b100000), C_R, 2, 32'd10, 1'b1, 1'b1, w);

        // slow load followed by a dependent add
        ack_lat = 3;
        ram_rdata = 32'd7;
        issue(it_f(5'd0, 5'd3, 16'd0), C_LW, 3, 32'd7, 1'b1, 1'b0, w);
        issue(rt_f(5'd3, 5'd3, 5'd4, 6'b100000), C_R, 4, 32'd14, 1'b1, 1'b1, w);
        check_val("lu_waits", 64'(w), 64'd4);
        ack_lat = 0;

        // ALU functions
        issue(rt_f(5'd1, 5'd1, 5'd5, 6'b100010), C_R, 5, 32'd0, 1'b1, 1'b1, w);
        @(posedge clk);
        #2;
        check_val("zero_after_sub", 64'(zero), 64'd1);
        issue(it_f(5'd0, 5'd6, 16'hFFFF), C_ADDI, 6, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
        issue(rt_f(5'd6, 5'd1, 5'd7, 6'b101010), C_R, 7, 32'd1, 1'b1, 1'b1, w);
        issue(rt_f(5'd1, 5'd6, 5'd8, 6'b101010), C_R, 8, 32'd0, 1'b1, 1'b1, w);
        issue(rt_f(5'd6, 5'd1, 5'd9, 6'b100100), C_R, 9, 32'd5, 1'b1, 1'b1, w);
        issue(rt_f(5'd1, 5'd0, 5'd10, 6'b100111), C_R, 10, 32'hFFFF_FFFA, 1'b1, 1'b1, w);
        issue(rt_f(5'd1, 5'd2, 5'd17, 6'b100101), C_R, 17, 32'd15, 1'b1, 1'b1, w);
        issue(it_f(5'd1, 5'd11, 16'h00F0), C_ORI, 11, 32'h0000_00F5, 1'b1, 1'b1, w);
        @(posedge clk);
        #2;
        check_val("zero_after_ori", 64'(zero), 64'd0);
        issue(rt_f(5'd2, 5'd1, 5'd12, 6'b000000), C_SUBR, 12, 32'd5, 1'b1, 1'b1, w);
        issue(rt_f(5'd1, 5'd2, 5'd13, 6'b000000), C_R, 13, 32'd15, 1'b1, 1'b1, w);

        // store with zero-latency acknowledge
        issue(it_f(5'd0, 5'd1, 16'd8), C_SW, 0, 32'd0, 1'b0, 1'b0, w);
        #3;
        check_val("sw_seimm", 64'(seimm), 64'd8);
        @(posedge clk);
        #7;
        check_val("sw_we", 64'(ram_we), 64'd1);
        check_val("sw_re", 64'(ram_re), 64'd0);
        check_val("sw_addr", 64'(ram_addr), 64'd8);
        check_val("sw_wdata", 64'(ram_wdata), 64'd5);
        check_val("sw_in_ready", 64'(in_ready), 64'd1);

        // store data forwarded from the preceding instruction
        issue(it_f(5'd0, 5'd18, 16'h0077), C_ADDI, 18, 32'h77, 1'b1, 1'b1, w);
        issue(it_f(5'd0, 5'd18, 16'd12), C_SW, 0, 32'd0, 1'b0, 1'b0, w);
        @(posedge clk);
        #7;
        check_val("swf_wdata", 64'(ram_wdata), 64'h77);
        check_val("swf_addr", 64'(ram_addr), 64'd12);

        // read and write strobes together behave as a load
        ram_rdata = 32'h1234;
        issue(it_f(5'd0, 5'd14, 16'd16), C_LWSW, 14, 32'h1234, 1'b1, 1'b1, w);
        @(posedge clk);
        #7;
        check_val("rw_re", 64'(ram_re), 64'd1);
        check_val("rw_we", 64'(ram_we), 64'd0);
        check_val("rw_addr", 64'(ram_addr), 64'd16);

        // writes to r0 are discarded
        issue(rt_f(5'd1, 5'd1, 5'd0, 6'b100000), C_R, 0, 32'd0, 1'b0, 1'b0, w);
        issue(rt_f(5'd0, 5'd1, 5'd15, 6'b100000), C_R, 15, 32'd5, 1'b1, 1'b1, w);

        // reset during a pending load
        ack_lat = 20;
        issue(it_f(5'd0, 5'd3, 16'd32), C_LW, 0, 32'd0, 1'b0, 1'b0, w);
        @(posedge clk);
        #2;
        check_val("pend_re", 64'(ram_re), 64'd1);
        check_val("pend_addr", 64'(ram_addr), 64'd32);
        check_val("pend_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_re", 64'(ram_re), 64'd0);
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_val("mid_rst_addr", 64'(ram_addr), 64'd0);
        check_val("mid_rst_zero", 64'(zero), 64'd0);
        ack_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_in_ready", 64'(in_ready), 64'd1);
        stray_ack = 1'b1;
        @(negedge clk);
        #2;
        check_val("stray_re", 64'(ram_re), 64'd0);
        check_val("stray_we", 64'(ram_we), 64'd0);
        check_val("stray_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        issue(rt_f(5'd1, 5'd2, 5'd16, 6'b100000), C_R, 16, 32'd0, 1'b1, 1'b1, w);

        repeat (5) @(posedge clk);
        check_val("sb_empty", 64'(sbq.size()), 64'd0);

        // 16-bit, 8-register build
        @(negedge clk);
        ins2 = it_f(5'd0, 5'd7, 16'hFFFF);
        ctl2 = C_ADDI;
        in_valid2 = 1'b1;
        #1;
        check_val("w16_in_ready", 64'(in_ready2), 64'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        #3;
        check_val("w16_seimm", 64'(seimm2), 64'hFFFF);
        @(posedge clk);
        #2;
        check_val("w16_wb_valid", 64'(wb_valid2), 64'd1);
        check_val("w16_wb_reg", 64'(wb_reg2), 64'd7);
        check_val("w16_wb_data", 64'(wb_data2), 64'hFFFF);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
